// File: rtl/fp_mul_iter_if.sv
// fp_mul_iter_if: operand/result valid-ready bundle for fp_mul_iter.
interface fp_mul_iter_if #(
  parameter int exp_width = 8,
  parameter int mant_width = 24
);
  logic valid_in;
  logic ready_out;
  logic [exp_width+mant_width-1:0] a;
  logic [exp_width+mant_width-1:0] b;
  logic [2:0] round_mode;
  logic valid_out;
  logic ready_in;
  logic [exp_width+mant_width-1:0] out;
  logic [4:0] exceptions;
  modport master (output valid_in, a, b, round_mode, ready_in, input ready_out, valid_out, out, exceptions);
  modport slave (input valid_in, a, b, round_mode, ready_in, output ready_out, valid_out, out, exceptions);
endinterface

// File: rtl/fp_mul_iter.sv
// fp_mul_iter: iterative radix-2^RADIX_BITS IEEE-754 multiplier with valid/ready handshake.
// Define FP_MUL_ITER_EARLY_OUT_EN to send NaN/inf/zero operands straight to rounding.
module fp_mul_iter #(
  parameter int exp_width = 8,
  parameter int mant_width = 24,
  parameter int RADIX_BITS = 4
) (
  input logic clk,
  input logic rst_l,
  fp_mul_iter_if.slave io
);
  localparam int E = exp_width, M = mant_width, W = E + M, R = RADIX_BITS, P = 2 * M;
  localparam int ITER = (M + R - 1) / R;
  localparam int CW = $clog2(ITER + 1);
  localparam int XW = E + $clog2(M) + 3;
  localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (E - 1)) - 1);
  localparam logic signed [XW-1:0] EMIN_X = XW'(2 - (1 << (E - 1)));
  localparam logic signed [XW-1:0] EMIN1_X = XW'(1 - (1 << (E - 1)));
  localparam logic signed [XW-1:0] SHMAX = XW'(M + 2);
  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;
  state_t r_state;
  logic r_valid, r_sign, r_nan, r_nv, r_inf, r_zero;
  logic [2:0] r_rm;
  logic [4:0] r_exc;
  logic [W-1:0] r_out;
  logic [M-1:0] r_mplr;
  logic [P-1:0] r_mcand, r_acc;
  logic [CW-1:0] r_cnt;
  logic signed [XW-1:0] r_exp_sum;
  function automatic int lzc(input logic [M-1:0] m);
    lzc = M;
    for (int i = 0; i < M; i++) if (m[i]) lzc = M - 1 - i;
  endfunction
  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:M-1]) & (|x[M-2:0]);
  endfunction
  function automatic logic is_inf(input logic [W-1:0] x);
    return (&x[W-2:M-1]) & ~(|x[M-2:0]);
  endfunction
  function automatic logic is_zero(input logic [W-1:0] x);
    return ~(|x[W-2:0]);
  endfunction
  function automatic logic [M-1:0] norm_m(input logic [W-1:0] x);
    logic [M-1:0] m;
    m = {|x[W-2:M-1], x[M-2:0]};
    return m << lzc(m);
  endfunction
  // Unbiased exponent; subnormals are renormalised so the hidden bit is always set.
  function automatic logic signed [XW-1:0] norm_e(input logic [W-1:0] x);
    return |x[W-2:M-1] ? XW'(x[W-2:M-1]) - BIAS_X : EMIN_X - XW'(lzc({1'b0, x[M-2:0]}));
  endfunction
  function automatic logic rinc(input logic [2:0] rm, input logic sg, input logic lsb, input logic g, input logic s);
    return rm == 3'd1 ? 1'b0 : rm == 3'd2 ? sg & (g | s) : rm == 3'd3 ? ~sg & (g | s) : rm == 3'd4 ? g : g & (s | lsb);
  endfunction
  logic w_ready, w_accept, w_skip, w_nan, w_inf, w_zero, w_nv;
  assign w_ready = r_state == IDLE || (r_state == DONE && io.ready_in);
  assign w_accept = io.valid_in && w_ready;
  assign io.ready_out = w_ready;
  assign io.valid_out = r_valid;
  assign io.out = r_out;
  assign io.exceptions = r_exc;
  assign w_nan = is_nan(io.a) | is_nan(io.b);
  assign w_inf = is_inf(io.a) | is_inf(io.b);
  assign w_zero = is_zero(io.a) | is_zero(io.b);
  assign w_nv = (is_nan(io.a) & ~io.a[M-2]) | (is_nan(io.b) & ~io.b[M-2]) |
                (is_inf(io.a) & is_zero(io.b)) | (is_zero(io.a) & is_inf(io.b));
`ifdef FP_MUL_ITER_EARLY_OUT_EN
  assign w_skip = w_nan | w_inf | w_zero;
`else
  assign w_skip = 1'b0;
`endif
  logic w_hi, w_tiny_pre, w_tiny, w_inc, w_inc0, w_of, w_nx, w_ovf_inf;
  logic [P-1:0] w_sig;
  logic [M+1:0] w_v0, w_v, w_mask;
  logic [XW-1:0] w_sh;
  logic signed [XW-1:0] w_e, w_dist, w_er, w_ex;
  logic [M:0] w_r;
  logic [M-1:0] w_mant;
  logic [W-1:0] w_inf_v, w_res;
  logic [4:0] w_exc;
  // Product is compressed to {significand, guard, sticky} before any denormalising shift.
  always_comb begin
    w_hi = r_acc[P-1];
    w_e = r_exp_sum + XW'(w_hi);
    w_sig = w_hi ? r_acc : r_acc << 1;
    w_v0 = {w_sig[P-1:M-1], |w_sig[M-2:0]};
    w_tiny_pre = w_e < EMIN_X;
    w_dist = EMIN_X - w_e;
    w_sh = w_tiny_pre ? (w_dist > SHMAX ? SHMAX : w_dist) : '0;
    w_mask = ~({(M+2){1'b1}} << w_sh);
    w_v = (w_v0 >> w_sh) | {{(M+1){1'b0}}, |(w_v0 & w_mask)};
    w_er = w_tiny_pre ? EMIN_X : w_e;
    w_inc = rinc(r_rm, r_sign, w_v[2], w_v[1], w_v[0]);
    w_inc0 = rinc(r_rm, r_sign, w_v0[2], w_v0[1], w_v0[0]);
    w_r = {1'b0, w_v[M+1:2]} + (M+1)'(w_inc);
    w_mant = w_r[M] ? w_r[M:1] : w_r[M-1:0];
    w_ex = w_er + XW'(w_r[M]);
    w_of = w_ex > BIAS_X;
    w_nx = w_v[1] | w_v[0];
    w_tiny = w_tiny_pre & ~(w_e == EMIN1_X && (&w_v0[M+1:2]) && w_inc0);
    w_ovf_inf = ~(r_rm == 3'd1 || (r_rm == 3'd2 && !r_sign) || (r_rm == 3'd3 && r_sign));
    w_inf_v = {r_sign, {E{1'b1}}, {(M-1){1'b0}}};
    w_res = r_nan ? {1'b0, {E{1'b1}}, 1'b1, {(M-2){1'b0}}} : r_inf ? w_inf_v :
            r_zero ? {r_sign, {(W-1){1'b0}}} :
            w_of ? (w_ovf_inf ? w_inf_v : {r_sign, {(E-1){1'b1}}, 1'b0, {(M-1){1'b1}}}) :
            {r_sign, w_mant[M-1] ? E'(w_ex + BIAS_X) : {E{1'b0}}, w_mant[M-2:0]};
    w_exc = r_nan ? {r_nv, 4'b0} : (r_inf | r_zero) ? 5'b0 : {2'b0, w_of, w_tiny & w_nx, w_nx | w_of};
  end
  always_ff @(posedge clk)
    if (!rst_l) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_out <= '0;
      r_exc <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        MUL: begin
          r_acc <= r_acc + r_mcand * P'(r_mplr[R-1:0]);
          r_mcand <= r_mcand << R;
          r_mplr <= r_mplr >> R;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) r_state <= ROUND;
        end
        ROUND: begin
          r_out <= w_res;
          r_exc <= w_exc;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (io.ready_in) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: ;
      endcase
      if (w_accept) begin
        r_sign <= io.a[W-1] ^ io.b[W-1];
        r_rm <= io.round_mode;
        r_exp_sum <= norm_e(io.a) + norm_e(io.b);
        r_mcand <= {{M{1'b0}}, norm_m(io.a)};
        r_mplr <= norm_m(io.b);
        r_acc <= '0;
        r_cnt <= '0;
        r_nan <= w_nan | w_nv;
        r_nv <= w_nv;
        r_inf <= w_inf;
        r_zero <= w_zero;
        r_state <= w_skip ? ROUND : MUL;
      end
    end
endmodule

// File: tb/tb_fp_mul_iter.sv
// tb_fp_mul_iter: directed vectors for fp_mul_iter, default radix plus radix 1/8/24 copies.
module tb_fp_mul_iter;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int total = 0;
  int bad = 0;
  int n;
`ifdef FP_MUL_ITER_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 7;
`endif
  always #5 clk = ~clk;
  fp_mul_iter_if io ();
  fp_mul_iter dut (.clk(clk), .rst_l(rst_l), .io(io));
  localparam int RX [3] = '{1, 8, 24};
  logic [31:0] ax_a, ax_b;
  logic ax_valid, ax_ready;
  logic [31:0] ax_out [3];
  logic [4:0] ax_exc [3];
  logic ax_vout [3];
  logic ax_rdy [3];
  for (genvar g = 0; g < 3; g++) begin : g_ax
    fp_mul_iter_if xi ();
    fp_mul_iter #(.RADIX_BITS(RX[g])) u (.clk(clk), .rst_l(rst_l), .io(xi));
    assign xi.valid_in = ax_valid;
    assign xi.a = ax_a;
    assign xi.b = ax_b;
    assign xi.round_mode = 3'd0;
    assign xi.ready_in = ax_ready;
    assign ax_out[g] = xi.out;
    assign ax_exc[g] = xi.exceptions;
    assign ax_vout[g] = xi.valid_out;
    assign ax_rdy[g] = xi.ready_out;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    io.a = a;
    io.b = b;
    io.round_mode = rm;
    io.valid_in = 1'b1;
    step();
    io.valid_in = 1'b0;
    io.a = '1;
    io.b = '1;
    io.round_mode = 3'd7;
  endtask
  task automatic wait_valid();
    n = 0;
    while (!io.valid_out && n < 40) begin
      step();
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                     input logic [31:0] want, input logic [4:0] wexc, input int lat);
    issue(a, b, rm);
    wait_valid();
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_out"}, io.out, want);
    chk({tag, "_exc"}, 32'(io.exceptions), 32'(wexc));
    step();
  endtask
  initial begin
    io.valid_in = 1'b0;
    io.ready_in = 1'b1;
    io.a = '0;
    io.b = '0;
    io.round_mode = 3'd0;
    ax_a = '0;
    ax_b = '0;
    ax_valid = 1'b0;
    ax_ready = 1'b0;
    step();
    step();
    chk("rst_vout", 32'(io.valid_out), 32'(0));
    chk("rst_out", io.out, 32'h0);
    chk("rst_exc", 32'(io.exceptions), 32'(0));
    rst_l = 1'b1;
    step();
    chk("rst_rdy", 32'(io.ready_out), 32'(1));
    run("mul15x2", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 7);
    chk("consumed", 32'(io.valid_out), 32'(0));
    run("neg_rdn", 32'hBFC00000, 32'h40000000, 3'd2, 32'hC0400000, 5'b00000, 7);
    run("inf_x_0", 32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, SPL);
    run("snan", 32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, SPL);
    run("qnan", 32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000, SPL);
    run("negzero", 32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 5'b00000, SPL);
    run("inf_neg", 32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 5'b00000, SPL);
    run("ovf_rne", 32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101, 7);
    run("ovf_rtz", 32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101, 7);
    run("sub_min", 32'h00000001, 32'h3F800000, 3'd0, 32'h00000001, 5'b00000, 7);
    run("sub_half", 32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 5'b00000, 7);
    run("uf_rne", 32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011, 7);
    run("uf_rup", 32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 5'b00011, 7);
    run("nx_rne", 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001, 7);
    run("nx_rup", 32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001, 7);
    io.ready_in = 1'b0;
    issue(32'h3FC00000, 32'h40000000, 3'd0);
    wait_valid();
    chk("bp_lat", 32'(n), 32'(7));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vout", 32'(io.valid_out), 32'(1));
      chk("bp_out", io.out, 32'h40400000);
      chk("bp_rdy", 32'(io.ready_out), 32'(0));
    end
    io.ready_in = 1'b1;
    io.a = 32'h40000000;
    io.b = 32'h40400000;
    io.round_mode = 3'd0;
    io.valid_in = 1'b1;
    #1;
    chk("b2b_rdy", 32'(io.ready_out), 32'(1));
    step();
    io.valid_in = 1'b0;
    io.a = '1;
    io.b = '1;
    chk("b2b_vout", 32'(io.valid_out), 32'(0));
    chk("mul_rdy", 32'(io.ready_out), 32'(0));
    wait_valid();
    chk("b2b_lat", 32'(n), 32'(7));
    chk("b2b_out", io.out, 32'h40C00000);
    chk("b2b_exc", 32'(io.exceptions), 32'(0));
    step();
    issue(32'h3FC00000, 32'h40000000, 3'd0);
    chk("mid_rdy", 32'(io.ready_out), 32'(0));
    step();
    step();
    rst_l = 1'b0;
    step();
    chk("mid_vout", 32'(io.valid_out), 32'(0));
    chk("mid_out", io.out, 32'h0);
    chk("mid_exc", 32'(io.exceptions), 32'(0));
    chk("mid_rdy1", 32'(io.ready_out), 32'(1));
    rst_l = 1'b1;
    run("post_rst", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 7);
    ax_a = 32'h00000001;
    ax_b = 32'h3F800000;
    ax_valid = 1'b1;
    step();
    ax_valid = 1'b0;
    ax_a = '1;
    ax_b = '1;
    repeat (30) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ax%0d_vout", RX[i]), 32'(ax_vout[i]), 32'(1));
      chk($sformatf("ax%0d_sub", RX[i]), ax_out[i], 32'h00000001);
      chk($sformatf("ax%0d_subexc", RX[i]), 32'(ax_exc[i]), 32'(0));
    end
    ax_ready = 1'b1;
    step();
    ax_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("ax%0d_idle", RX[i]), 32'(ax_rdy[i]), 32'(1));
    ax_a = 32'h3FC00000;
    ax_b = 32'h40000000;
    ax_valid = 1'b1;
    step();
    ax_valid = 1'b0;
    ax_a = '0;
    ax_b = '0;
    repeat (30) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ax%0d_vout2", RX[i]), 32'(ax_vout[i]), 32'(1));
      chk($sformatf("ax%0d_mul", RX[i]), ax_out[i], 32'h40400000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
